// File: rtl/uart_pkg.sv
// Shared constants, types and byte-builder helpers for the UART TX reporter.
package uart_pkg;

  localparam int unsigned CNT_W   = 14;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned MAX_VAL = 9999;
  localparam int unsigned ACK_LEN = 6;
  localparam int unsigned ERR_LEN = 4;
  localparam int unsigned RPT_LEN = 9 + DIGITS;
  localparam int unsigned IDX_W   = $clog2(RPT_LEN);
  localparam int unsigned STEP_W  = $clog2(CNT_W + 1);

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_U     = 8'h55;

  localparam logic [2:0] CMD_RUN   = 3'd0;
  localparam logic [2:0] CMD_CLEAR = 3'd1;
  localparam logic [2:0] CMD_MODE  = 3'd2;
  localparam logic [2:0] CMD_SETHZ = 3'd3;

  typedef enum logic [1:0] {IDLE, CONV, SEND_ACK, SEND_RPT} state_t;

  typedef struct packed {
    logic run;
    logic up;
  } snap_t;

  // Byte idx of an acknowledgement ("OK:x" CR LF or "ER" CR LF).
  function automatic logic [7:0] ack_byte(input logic [2:0] code, input logic [IDX_W-1:0] idx);
    logic [7:0]  b;
    int unsigned i;
    i = 32'(idx);
    b = 8'h00;
    if (code > CMD_SETHZ) begin
      case (i)
        0: b = CH_E;
        1: b = CH_R;
        2: b = CH_CR;
        3: b = CH_LF;
        default: b = 8'h00;
      endcase
    end else begin
      case (i)
        0: b = CH_O;
        1: b = CH_K;
        2: b = CH_COLON;
        3: begin
          case (code)
            CMD_RUN:   b = CH_R;
            CMD_CLEAR: b = CH_C;
            CMD_MODE:  b = CH_M;
            CMD_SETHZ: b = CH_H;
            default:   b = 8'h00;
          endcase
        end
        4: b = CH_CR;
        5: b = CH_LF;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Byte idx of a status report ("CNT=dddd xy" CR LF).
  function automatic logic [7:0] rpt_byte(input logic [BCD_W-1:0] bcd, input snap_t s,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0]       b;
    logic [BCD_W-1:0] t;
    int unsigned      i;
    i = 32'(idx);
    b = 8'h00;
    t = '0;
    if (i < 4) begin
      case (i)
        0: b = CH_C;
        1: b = CH_N;
        2: b = CH_T;
        default: b = CH_EQ;
      endcase
    end else if (i < 4 + DIGITS) begin
      t = bcd >> (4 * (DIGITS - 1 - (i - 4)));
      b = CH_0 + {4'h0, t[3:0]};
    end else begin
      case (i - 4 - DIGITS)
        0: b = CH_SP;
        1: b = s.run ? CH_R : CH_S;
        2: b = s.up ? CH_U : CH_D;
        3: b = CH_CR;
        4: b = CH_LF;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_reporter_if.sv
// Request side (decoder / counter core) and TX FIFO write side of the reporter.
interface uart_tx_reporter_if;
  import uart_pkg::*;

  logic             report_req;
  logic             ack_req;
  logic [2:0]       cmd_code;
  logic [CNT_W-1:0] count_val;
  logic             run_state;
  logic             mode_up;
  logic             fifo_full;
  logic             push;
  logic [7:0]       push_data;
  logic             busy;

  modport master (
    output report_req, ack_req, cmd_code, count_val, run_state, mode_up, fifo_full,
    input  push, push_data, busy
  );

  modport slave (
    input  report_req, ack_req, cmd_code, count_val, run_state, mode_up, fifo_full,
    output push, push_data, busy
  );

endinterface

// File: rtl/uart_tx_reporter_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, done pulses CNT_W+1 cycles after start.
module bin2bcd_seq
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [CNT_W-1:0]  sh;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  adj_c;
  logic [STEP_W-1:0] cnt;
  logic              run;

  // Add 3 to every digit of 5 or more before the next shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj_c[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        acc <= '0;
        cnt <= STEP_W'(CNT_W);
        run <= 1'b1;
      end else if (run) begin
        acc <= {adj_c[BCD_W-2:0], sh[CNT_W-1]};
        sh  <= sh << 1;
        cnt <= cnt - STEP_W'(1);
        if (cnt == STEP_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/uart_tx_reporter.sv
// Builds ASCII acks and status reports and pushes them byte-by-byte into the TX FIFO.
module uart_tx_reporter
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  uart_tx_reporter_if.slave  bus
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             ack_pend;
  logic [2:0]       ack_code;
  logic             rpt_pend;
  logic [2:0]       cur_code;
  snap_t            snap;
  logic [7:0]       push_data_r;
  logic             busy_r;

  logic             send_c;
  logic             push_c;
  logic             last_c;
  logic             start_rpt_c;
  logic [CNT_W-1:0] bin_c;
  logic [7:0]       nxt_byte_c;
  logic [BCD_W-1:0] bcd;
  logic             bcd_done;

  assign send_c      = (state == SEND_ACK) || (state == SEND_RPT);
  assign push_c      = send_c && !bus.fifo_full;
  assign start_rpt_c = (state == IDLE) && !ack_pend && rpt_pend;
  assign bin_c       = (bus.count_val > CNT_W'(MAX_VAL)) ? CNT_W'(MAX_VAL) : bus.count_val;
  assign nxt_byte_c  = (state == SEND_ACK) ? ack_byte(cur_code, idx + IDX_W'(1))
                                           : rpt_byte(bcd, snap, idx + IDX_W'(1));

  always_comb begin
    last_c = 1'b0;
    if (state == SEND_ACK)
      last_c = (idx == IDX_W'(((cur_code > CMD_SETHZ) ? ERR_LEN : ACK_LEN) - 1));
    else if (state == SEND_RPT)
      last_c = (idx == IDX_W'(RPT_LEN - 1));
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_rpt_c),
    .bin   (bin_c),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      ack_pend    <= 1'b0;
      ack_code    <= '0;
      rpt_pend    <= 1'b0;
      cur_code    <= '0;
      snap        <= '0;
      push_data_r <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      // A request landing in the same cycle its flag is consumed stays pending.
      if ((state == IDLE) && ack_pend) ack_pend <= 1'b0;
      if (bus.ack_req) begin
        ack_pend <= 1'b1;
        ack_code <= bus.cmd_code;
      end
      if (start_rpt_c) rpt_pend <= 1'b0;
      if (bus.report_req) rpt_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (ack_pend) begin
            state       <= SEND_ACK;
            cur_code    <= ack_code;
            idx         <= '0;
            push_data_r <= ack_byte(ack_code, '0);
            busy_r      <= 1'b1;
          end else if (rpt_pend) begin
            state  <= CONV;
            snap   <= '{run: bus.run_state, up: bus.mode_up};
            busy_r <= 1'b1;
          end
        end
        CONV: begin
          if (bcd_done) begin
            state       <= SEND_RPT;
            idx         <= '0;
            push_data_r <= rpt_byte(bcd, snap, '0);
          end
        end
        SEND_ACK, SEND_RPT: begin
          if (push_c) begin
            if (last_c) begin
              state       <= IDLE;
              idx         <= '0;
              push_data_r <= 8'h00;
              busy_r      <= 1'b0;
            end else begin
              idx         <= idx + IDX_W'(1);
              push_data_r <= nxt_byte_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.push      = push_c;
  assign bus.push_data = push_data_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_reporter.sv
// Scoreboard bench for uart_tx_reporter: expected bytes queued at request time, checked on every push.
module tb_uart_tx_reporter;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  logic rand_en   = 1'b0;
  logic full_rand = 1'b0;
  logic full_dir  = 1'b0;

  uart_tx_reporter_if bus ();

  uart_tx_reporter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.fifo_full = rand_en ? full_rand : full_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference messages built straight from the message formats.
  function automatic void exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  function automatic void exp_ack(input int code);
    string l;
    l = "RCMH";
    if (code < 4) begin
      exp_str("OK:");
      exp_q.push_back(l[code]);
    end else begin
      exp_str("ER");
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void exp_rpt(input int v, input bit run, input bit up);
    int c;
    c = (v > 9999) ? 9999 : v;
    exp_str("CNT=");
    exp_str($sformatf("%04d", c));
    exp_str(run ? " R" : " S");
    exp_str(up ? "U" : "D");
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Monitor: every pushed byte must be the next expected byte.
  always @(negedge clk) begin
    if (rst && bus.push) begin
      if (exp_q.size() == 0) fail("unexpected_push");
      else check("byte", 32'(bus.push_data), 32'(exp_q.pop_front()));
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    full_rand = ($urandom_range(0, 3) == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit a, input int code, input bit r);
    bus.ack_req    = a;
    bus.cmd_code   = 3'(code);
    bus.report_req = r;
    tick();
    bus.ack_req    = 1'b0;
    bus.report_req = 1'b0;
  endtask

  task automatic set_cnt(input int v, input bit run, input bit up);
    bus.count_val = CNT_W'(v);
    bus.run_state = run;
    bus.mode_up   = up;
  endtask

  task automatic wait_first_push(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.push) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail("first_push_timeout");
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail("idle_timeout");
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    int t;
    int c;
    bus.report_req = 1'b0;
    bus.ack_req    = 1'b0;
    bus.cmd_code   = '0;
    set_cnt(0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_push", 32'(bus.push), 32'd0);
    check("rst_push_data", 32'(bus.push_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Ack "OK:R": latency t+2, back-to-back, busy drops afterwards
    exp_ack(0);
    t = cyc;
    issue(1'b1, 0, 1'b0);
    wait_first_push(c);
    check("ack_latency", 32'(c - t), 32'd2);
    check("ack_busy_high", 32'(bus.busy), 32'd1);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      check("ack_back_to_back", 32'(bus.push), 32'd1);
    end
    @(negedge clk);
    check("ack_busy_fall", 32'(bus.busy), 32'd0);
    wait_idle(50);

    // Report 123, running, down: first push at t+CNT_W+3
    set_cnt(123, 1'b1, 1'b0);
    exp_rpt(123, 1'b1, 1'b0);
    t = cyc;
    issue(1'b0, 0, 1'b1);
    wait_first_push(c);
    check("rpt_latency", 32'(c - t), 32'(CNT_W + 3));
    wait_idle(100);

    // Clamp above 9999
    set_cnt(12000, 1'b0, 1'b1);
    exp_rpt(12000, 1'b0, 1'b1);
    issue(1'b0, 0, 1'b1);
    wait_idle(100);

    // Error ack
    exp_ack(6);
    issue(1'b1, 6, 1'b0);
    wait_idle(50);

    // FIFO full for 5 cycles on the 3rd report byte
    set_cnt(4567, 1'b1, 1'b1);
    exp_rpt(4567, 1'b1, 1'b1);
    issue(1'b0, 0, 1'b1);
    wait_first_push(c);
    tick();
    tick();
    full_dir = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_push_low", 32'(bus.push), 32'd0);
      check("full_data_hold", 32'(bus.push_data), 32'h54);
      tick();
    end
    full_dir = 1'b0;
    wait_idle(100);

    // Simultaneous ack+report, count changed before the report snapshot;
    // then merged report requests and a last-wins ack while busy
    set_cnt(555, 1'b0, 1'b1);
    exp_ack(3);
    exp_rpt(8765, 1'b0, 1'b1);
    exp_ack(7);
    exp_rpt(8765, 1'b0, 1'b1);
    issue(1'b1, 3, 1'b1);
    tick();
    set_cnt(8765, 1'b0, 1'b1);
    repeat (8) tick();
    issue(1'b0, 0, 1'b1);
    tick();
    issue(1'b1, 1, 1'b1);
    tick();
    issue(1'b1, 7, 1'b1);
    wait_idle(300);

    // Reset mid-report with an ack pending
    set_cnt(42, 1'b0, 1'b0);
    exp_rpt(42, 1'b0, 1'b0);
    issue(1'b0, 0, 1'b1);
    wait_first_push(c);
    tick();
    issue(1'b1, 0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_push", 32'(bus.push), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check("pending_cleared_busy", 32'(bus.busy), 32'd0);
    exp_ack(2);
    issue(1'b1, 2, 1'b0);
    wait_idle(50);

    // Randomized traffic with a random FIFO-full pattern
    rand_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      int code;
      int v;
      bit run;
      bit up;
      kind = $urandom_range(0, 2);
      code = $urandom_range(0, 7);
      v    = $urandom_range(0, 16383);
      run  = 1'($urandom_range(0, 1));
      up   = 1'($urandom_range(0, 1));
      set_cnt(v, run, up);
      if (kind != 1) exp_ack(code);
      if (kind != 0) exp_rpt(v, run, up);
      issue(kind != 1, code, kind != 0);
      wait_idle(600);
    end
    rand_en = 1'b0;

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
